// File: rtl/ram_sp_pipe.sv
// Single-port synchronous RAM with a valid/ready request port, per-byte
// write enables, a 1- or 2-cycle read pipeline and a fill-with-constant
// clear engine that runs after reset and on command.
module ram_sp_pipe #(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    ADDR_WIDTH    = 8,
  parameter int                    READ_LATENCY  = 1,
  parameter int                    INIT_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
  input  logic                    CLK_I,
  input  logic                    RST_N_I,
  input  logic                    REQ_VALID_I,
  output logic                    REQ_READY_O,
  input  logic                    WE_I,
  input  logic [DATA_WIDTH/8-1:0] BE_I,
  input  logic [ADDR_WIDTH-1:0]   ADDR_I,
  input  logic [DATA_WIDTH-1:0]   DATA_I,
  input  logic                    INIT_START_I,
  output logic                    RSP_VALID_O,
  output logic [DATA_WIDTH-1:0]   DATA_O,
  output logic [ADDR_WIDTH-1:0]   ADDR_O,
  output logic                    INIT_BUSY_O
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH/8;

  if (DATA_WIDTH <= 0 || (DATA_WIDTH % 8) != 0) begin : g_bad_dw
    $error("ram_sp_pipe: DATA_WIDTH must be a positive multiple of 8");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_rl
    $error("ram_sp_pipe: READ_LATENCY must be 1 or 2");
  end

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [READ_LATENCY:1]   vld_pipe;
  logic [DATA_WIDTH-1:0]   dat_pipe [1:READ_LATENCY];
  logic [ADDR_WIDTH-1:0]   adr_pipe [1:READ_LATENCY];

  logic accept, wr, rd;

  assign accept = REQ_VALID_I & ready;
  assign wr     = accept & WE_I;
  assign rd     = accept & ~WE_I;

  // Control FSM: ready is registered so it follows the state one cycle after
  // a transition (drops the cycle after INIT_START, rises after the last fill).
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state <= (INIT_ON_RESET != 0) ? S_INIT : S_RUN;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          if (cnt == {ADDR_WIDTH{1'b1}}) begin
            state <= S_RUN;
            ready <= 1'b1;
          end else begin
            cnt   <= cnt + 1'b1;
            ready <= 1'b0;
          end
        end
        default: begin
          if (INIT_START_I) begin
            state <= S_INIT;
            cnt   <= '0;
            ready <= 1'b0;
          end else begin
            ready <= 1'b1;
          end
        end
      endcase
    end
  end

  assign REQ_READY_O = ready;
  assign INIT_BUSY_O = (state == S_INIT);

  // Array writes: clear engine fill or byte-masked request write. The array
  // is never reset; the reset gate only stops a fill write while held.
  always_ff @(posedge CLK_I) begin
    if (state == S_INIT && RST_N_I) begin
      mem[cnt] <= INIT_VALUE;
    end else if (wr) begin
      for (int b = 0; b < NB; b++) begin
        if (BE_I[b]) mem[ADDR_I][8*b +: 8] <= DATA_I[8*b +: 8];
      end
    end
  end

  // Read pipeline: stage 1 samples the array at acceptance; an optional
  // second stage adds one cycle. Data/address only move with a valid so the
  // outputs hold between responses.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      vld_pipe <= '0;
      for (int s = 1; s <= READ_LATENCY; s++) begin
        dat_pipe[s] <= '0;
        adr_pipe[s] <= '0;
      end
    end else begin
      vld_pipe[1] <= rd;
      if (rd) begin
        dat_pipe[1] <= mem[ADDR_I];
        adr_pipe[1] <= ADDR_I;
      end
      for (int s = 2; s <= READ_LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) begin
          dat_pipe[s] <= dat_pipe[s-1];
          adr_pipe[s] <= adr_pipe[s-1];
        end
      end
    end
  end

  assign RSP_VALID_O = vld_pipe[READ_LATENCY];
  assign DATA_O      = dat_pipe[READ_LATENCY];
  assign ADDR_O      = adr_pipe[READ_LATENCY];

endmodule

// File: tb/tb_ram_sp_pipe.sv
// Directed bench: u1 is 32-bit / 16 words / latency 1 / fill 0,
// u2 is 8-bit / 16 words / latency 2 / fill 0xFF. Both share clock and reset.
module tb_ram_sp_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // u1 signals
  logic        v1 = 0, we1 = 0, is1 = 0, rdy1, rv1, bz1;
  logic [3:0]  be1 = '0, a1 = '0, ao1;
  logic [31:0] d1 = '0, do1;
  // u2 signals
  logic        v2 = 0, we2 = 0, is2 = 0, rdy2, rv2, bz2;
  logic [0:0]  be2 = '0;
  logic [3:0]  a2 = '0, ao2;
  logic [7:0]  d2 = '0, do2;

  int npass = 0, ntot = 0, n = 0;
  logic stale;

  ram_sp_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1),
                .INIT_ON_RESET(1), .INIT_VALUE(32'h0)) u1 (
    .CLK_I(clk), .RST_N_I(rst_n), .REQ_VALID_I(v1), .REQ_READY_O(rdy1),
    .WE_I(we1), .BE_I(be1), .ADDR_I(a1), .DATA_I(d1), .INIT_START_I(is1),
    .RSP_VALID_O(rv1), .DATA_O(do1), .ADDR_O(ao1), .INIT_BUSY_O(bz1));

  ram_sp_pipe #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(2),
                .INIT_ON_RESET(1), .INIT_VALUE(8'hFF)) u2 (
    .CLK_I(clk), .RST_N_I(rst_n), .REQ_VALID_I(v2), .REQ_READY_O(rdy2),
    .WE_I(we2), .BE_I(be2), .ADDR_I(a2), .DATA_I(d2), .INIT_START_I(is2),
    .RSP_VALID_O(rv2), .DATA_O(do2), .ADDR_O(ao2), .INIT_BUSY_O(bz2));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wr1(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    v1 = 1; we1 = 1; a1 = a; d1 = d; be1 = be;
  endtask
  task automatic rd1(input logic [3:0] a);
    v1 = 1; we1 = 0; a1 = a; be1 = 4'hF;
  endtask
  task automatic wr2(input logic [3:0] a, input logic [7:0] d);
    v2 = 1; we2 = 1; a2 = a; d2 = d; be2 = 1'b1;
  endtask
  task automatic rd2(input logic [3:0] a);
    v2 = 1; we2 = 0; a2 = a;
  endtask

  initial begin
    // ---- reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready1", rdy1, 0);
    chk("rst_rv1", rv1, 0);
    chk("rst_data1", do1, 0);
    chk("rst_addr1", ao1, 0);
    chk("rst_busy1", bz1, 1);
    chk("rst_rv2", rv2, 0);
    chk("rst_data2", do2, 0);
    rst_n = 1;

    // ---- clear after reset lasts exactly DEPTH cycles
    n = 0;
    while (bz1 && n < 40) begin tick(); n++; end
    chk("init_cycles", n, 16);
    chk("init_ready1", rdy1, 1);
    chk("init_ready2", rdy2, 1);
    chk("init_busy2", bz2, 0);

    // ---- every address reads back the fill value 0 (back-to-back reads)
    for (int i = 0; i < 16; i++) begin
      rd1(4'(i));
      tick();
      chk("rd0_valid", rv1, 1);
      chk("rd0_data", do1, 0);
      chk("rd0_addr", ao1, 32'(i));
    end
    v1 = 0;
    tick();
    chk("rd0_done", rv1, 0);

    // ---- write then read next cycle, latency 1
    wr1(4'h3, 32'h0000_00A5, 4'hF);
    tick();
    chk("wr_norsp", rv1, 0);
    rd1(4'h3);
    tick();
    chk("raw_valid", rv1, 1);
    chk("raw_data", do1, 32'hA5);
    chk("raw_addr", ao1, 3);
    v1 = 0;
    tick();
    chk("pulse_once", rv1, 0);
    chk("hold_data", do1, 32'hA5);
    chk("hold_addr", ao1, 3);

    // ---- byte enables
    wr1(4'h5, 32'h1122_3344, 4'b1111);
    tick();
    wr1(4'h5, 32'hAABB_CCDD, 4'b0101);
    tick();
    rd1(4'h5);
    tick();
    chk("be_data", do1, 32'h11BB_33DD);
    wr1(4'h5, 32'hFFFF_FFFF, 4'b0000);
    tick();
    rd1(4'h5);
    tick();
    chk("be0_data", do1, 32'h11BB_33DD);
    // marker words for the aborted-clear check
    wr1(4'h0, 32'hDEAD_BEEF, 4'hF);
    tick();
    wr1(4'hF, 32'hDEAD_BEEF, 4'hF);
    tick();
    rd1(4'hF);
    tick();
    chk("marker", do1, 32'hDEAD_BEEF);
    v1 = 0;

    // ---- latency 2: three back-to-back reads
    wr2(4'h1, 8'h01); tick();
    wr2(4'h2, 8'h02); tick();
    wr2(4'h3, 8'h03); tick();
    rd2(4'h1); tick();
    chk("l2_first_empty", rv2, 0);
    rd2(4'h2); tick();
    chk("l2_v1", rv2, 1);
    chk("l2_a1", ao2, 1);
    chk("l2_d1", do2, 8'h01);
    rd2(4'h3); tick();
    v2 = 0;
    chk("l2_v2", rv2, 1);
    chk("l2_a2", ao2, 2);
    chk("l2_d2", do2, 8'h02);
    tick();
    chk("l2_v3", rv2, 1);
    chk("l2_a3", ao2, 3);
    chk("l2_d3", do2, 8'h03);
    tick();
    chk("l2_end", rv2, 0);

    // ---- read accepted together with a clear start
    rd2(4'h1); is2 = 1;
    tick();
    v2 = 0; is2 = 0;
    chk("clr_ready_drop", rdy2, 0);
    chk("clr_busy", bz2, 1);
    tick();
    chk("clr_old_valid", rv2, 1);
    chk("clr_old_data", do2, 8'h01);
    n = 0;
    while (!rdy2 && n < 40) begin tick(); n++; end
    chk("clr_ready_low_cycles", n + 1, 16);
    chk("clr_busy_done", bz2, 0);
    rd2(4'h0); tick();
    rd2(4'h3); tick();
    chk("clr_ff_0", do2, 8'hFF);
    rd2(4'hF); tick();
    v2 = 0;
    chk("clr_ff_3", do2, 8'hFF);
    tick();
    chk("clr_ff_F", do2, 8'hFF);

    // ---- reset mid-clear (u1) with reads in flight (u2)
    is1 = 1;
    tick();
    is1 = 0;
    chk("ab_busy", bz1, 1);
    chk("ab_ready", rdy1, 0);
    tick();
    rd2(4'h2); tick();
    rd2(4'h3); tick();
    v2 = 0;
    chk("ab_rsp_before", rv2, 1);
    chk("ab_addr_before", ao2, 2);
    #1 rst_n = 0;
    #1;
    chk("ab_rsp_now", rv2, 0);
    chk("ab_data_now", do2, 0);
    chk("ab_busy_rst", bz1, 1);
    chk("ab_ready_rst", rdy2, 0);
    @(posedge clk); #1;
    rst_n = 1;
    n = 0;
    stale = 0;
    while (bz1 && n < 40) begin
      tick(); n++;
      if (rv1 || rv2) stale = 1;
    end
    chk("ab_init_cycles", n, 16);
    chk("ab_no_stale", stale, 0);
    rd1(4'h0); tick();
    chk("ab_clr_0", do1, 0);
    rd1(4'hF); tick();
    v1 = 0;
    chk("ab_clr_F", do1, 0);
    chk("ab_clr_Fa", ao1, 32'hF);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
